memoria_rgb: RTL and testbench
==============================

Name: memoria_rgb

Overview:
- Keypad-entry memory for one RGB colour triple.
- Accepts decimal digits one at a time from the key decoder, strobed by `cambio_digito`.
- Builds a 3-digit entry (hundreds/tens/units) and exposes it for display.
- On a confirm key, stores the entry as the next 8-bit component (R, then G, then B) and flags `RGB_full` once all three are stored.

Parameters:
- MAX_VAL, 255, saturation limit applied to a confirmed 3-digit value.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- digito  input  5  key code from the decoder (see key map below).
- cambio_digito  input  1  key-event strobe; acted on at its rising edge only.
- u  output  5  units digit of the current entry (0-9).
- d  output  5  tens digit of the current entry (0-9).
- c  output  5  hundreds digit of the current entry (0-9).
- RGB_full  output  1  high when R, G and B have all been stored.
- r_val  output  8  stored red component.
- g_val  output  8  stored green component.
- b_val  output  8  stored blue component.

Behaviour:
- Reset (synchronous, active-high; wins over any key event in the same cycle):
  - u, d, c = 0.
  - r_val, g_val, b_val = 0.
  - Slot pointer = R.
  - RGB_full = 0.
  - Strobe edge register cleared.
- Edge detect:
  - Register `cambio_prev` <= cambio_digito every cycle.
  - Key event = cambio_digito & ~cambio_prev.
  - A strobe held high for several cycles produces exactly one event.
- Latency: an event sampled at edge N updates all outputs at edge N; the new values are visible after that edge.
- Key map (5-bit digito):
  - 0x00-0x09: digit. Shift the entry left: c<=d, d<=u, u<=digito. The old c is discarded, so the last three digits win.
  - 0x0A: confirm.
    - Value = c*100 + d*10 + u, computed at 10 bits.
    - If value > MAX_VAL it saturates to MAX_VAL; the result is truncated to 8 bits.
    - Write the value to the slot at the pointer (R→G→B) and advance the pointer.
    - Clear u, d, c to 0.
    - When the B write completes, RGB_full <= 1 at the same edge.
  - 0x0B: clear entry only: u, d, c = 0. Stored values are unchanged.
  - 0x0C: restart: same effect as reset.
  - 0x0D-0x1F (including 0x0F): ignored, no state change.
- Slot FSM:
  - States: SLOT_R, SLOT_G, SLOT_B, FULL.
  - Each confirm advances one state.
  - FULL holds until reset or restart; FULL drives RGB_full = 1.
- Behaviour while FULL:
  - Digit, confirm and clear-entry keys are ignored; u, d, c hold at 0.
  - Only restart (0x0C) or reset leaves FULL.
- Empty entry: confirming with no digits entered stores 0.
- Stored values hold indefinitely until reset or restart.

Test Plan:
- Reset then strobe digit 1 → u=1, d=0, c=0; RGB_full=0.
- Strobe 0x0F, then 0x09 → 0x0F has no effect; then u=9, d=1, c=0.
- Strobe 0x0A three times (after entry 1,9) → r_val=19, g_val=0, b_val=0; u=d=c=0; RGB_full=1 on the third confirm.
- Enter 3,0,0 and confirm → r_val=255 (saturated). Enter 1,2,3,4 → c=2, d=3, u=4; confirm → g_val=234.
- Hold cambio_digito high for 5 cycles with digit 7 → only one shift (u=7). While FULL, digit 5 and 0x0A are ignored. Strobe 0x0C → all cleared, RGB_full=0.
- Assert reset in the same cycle as a confirm strobe → reset wins: all outputs 0, pointer at R.

Source files
------------

// File: rtl/memoria_rgb.sv
// Keypad-entry memory for one RGB triple: 3-digit entry, confirm stores R then G then B.
// Latency: a key event sampled at edge N is visible after edge N; no backpressure (one event per strobe edge).
module memoria_rgb #(
  parameter int MAX_VAL = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] digito,
  input  logic       cambio_digito,
  output logic [4:0] u,
  output logic [4:0] d,
  output logic [4:0] c,
  output logic       RGB_full,
  output logic [7:0] r_val,
  output logic [7:0] g_val,
  output logic [7:0] b_val
);

  typedef enum logic [1:0] {
    SLOT_R,
    SLOT_G,
    SLOT_B,
    FULL
  } slot_t;

  localparam logic [4:0] KEY_CONF    = 5'h0A;
  localparam logic [4:0] KEY_CLR     = 5'h0B;
  localparam logic [4:0] KEY_RESTART = 5'h0C;
  localparam logic [9:0] MAX10       = 10'(MAX_VAL);
  localparam logic [7:0] MAX8        = 8'(MAX_VAL);

  slot_t      slot_q, slot_d;
  logic       cambio_prev;
  logic       evento;
  logic [4:0] u_d, d_d, c_d;
  logic [7:0] r_d, g_d, b_d;
  logic [9:0] valor;
  logic [7:0] valor_sat;

  assign evento   = cambio_digito & ~cambio_prev;
  assign RGB_full = (slot_q == FULL);

  // Worst case 9*100 + 9*10 + 9 = 999 still fits in 10 bits.
  assign valor     = ({5'd0, c} * 10'd100) + ({5'd0, d} * 10'd10) + {5'd0, u};
  assign valor_sat = (valor > MAX10) ? MAX8 : valor[7:0];

  always_comb begin
    slot_d = slot_q;
    u_d    = u;
    d_d    = d;
    c_d    = c;
    r_d    = r_val;
    g_d    = g_val;
    b_d    = b_val;
    if (evento) begin
      if (digito == KEY_RESTART) begin
        slot_d = SLOT_R;
        u_d    = 5'd0;
        d_d    = 5'd0;
        c_d    = 5'd0;
        r_d    = 8'd0;
        g_d    = 8'd0;
        b_d    = 8'd0;
      end else if (slot_q != FULL) begin
        if (digito <= 5'd9) begin
          c_d = d;
          d_d = u;
          u_d = digito;
        end else if (digito == KEY_CONF) begin
          u_d = 5'd0;
          d_d = 5'd0;
          c_d = 5'd0;
          case (slot_q)
            SLOT_R: begin
              r_d    = valor_sat;
              slot_d = SLOT_G;
            end
            SLOT_G: begin
              g_d    = valor_sat;
              slot_d = SLOT_B;
            end
            SLOT_B: begin
              b_d    = valor_sat;
              slot_d = FULL;
            end
            default: slot_d = FULL;
          endcase
        end else if (digito == KEY_CLR) begin
          u_d = 5'd0;
          d_d = 5'd0;
          c_d = 5'd0;
        end
      end
    end
  end

  // Restart keeps tracking the strobe so a held restart key does not re-trigger.
  always_ff @(posedge clk) begin
    if (reset) begin
      cambio_prev <= 1'b0;
      slot_q      <= SLOT_R;
      u           <= 5'd0;
      d           <= 5'd0;
      c           <= 5'd0;
      r_val       <= 8'd0;
      g_val       <= 8'd0;
      b_val       <= 8'd0;
    end else begin
      cambio_prev <= cambio_digito;
      slot_q      <= slot_d;
      u           <= u_d;
      d           <= d_d;
      c           <= c_d;
      r_val       <= r_d;
      g_val       <= g_d;
      b_val       <= b_d;
    end
  end

endmodule

// File: tb/tb_memoria_rgb.sv
// Directed bench for memoria_rgb: entry shifting, saturation, slot sequencing, strobe edges, reset priority.
module tb_memoria_rgb;

  logic       clk;
  logic       reset;
  logic [4:0] digito;
  logic       cambio_digito;
  logic [4:0] u, d, c;
  logic       RGB_full;
  logic [7:0] r_val, g_val, b_val;

  int errors = 0;
  int checks = 0;

  memoria_rgb #(.MAX_VAL(255)) dut (
    .clk          (clk),
    .reset        (reset),
    .digito       (digito),
    .cambio_digito(cambio_digito),
    .u            (u),
    .d            (d),
    .c            (c),
    .RGB_full     (RGB_full),
    .r_val        (r_val),
    .g_val        (g_val),
    .b_val        (b_val)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One strobe pulse; returns on a falling edge after the update edge.
  task automatic key(input logic [4:0] k);
    @(negedge clk);
    digito        = k;
    cambio_digito = 1'b1;
    @(negedge clk);
    cambio_digito = 1'b0;
    @(negedge clk);
  endtask

  task automatic chk_entry(input string tag, input int ce, input int de, input int ue);
    chk({tag, "_c"}, {27'd0, c}, ce);
    chk({tag, "_d"}, {27'd0, d}, de);
    chk({tag, "_u"}, {27'd0, u}, ue);
  endtask

  task automatic chk_store(input string tag, input int re, input int ge, input int be, input int fe);
    chk({tag, "_r"}, {24'd0, r_val}, re);
    chk({tag, "_g"}, {24'd0, g_val}, ge);
    chk({tag, "_b"}, {24'd0, b_val}, be);
    chk({tag, "_full"}, {31'd0, RGB_full}, fe);
  endtask

  initial begin
    reset         = 1'b1;
    digito        = 5'd0;
    cambio_digito = 1'b0;
    repeat (2) @(negedge clk);
    chk_entry("reset", 0, 0, 0);
    chk_store("reset", 0, 0, 0, 0);
    reset = 1'b0;

    key(5'd1);
    chk_entry("dig1", 0, 0, 1);
    chk("dig1_full", {31'd0, RGB_full}, 0);

    key(5'h0F);
    chk_entry("ign0F", 0, 0, 1);
    key(5'd9);
    chk_entry("dig9", 0, 1, 9);

    key(5'h0A);
    chk_entry("conf1", 0, 0, 0);
    chk_store("conf1", 19, 0, 0, 0);
    key(5'h0A);
    chk_store("conf2", 19, 0, 0, 0);
    key(5'h0A);
    chk_store("conf3", 19, 0, 0, 1);

    key(5'h0C);
    chk_entry("restart1", 0, 0, 0);
    chk_store("restart1", 0, 0, 0, 0);

    key(5'd3);
    key(5'd0);
    key(5'd0);
    chk_entry("e300", 3, 0, 0);
    key(5'h0A);
    chk_store("sat300", 255, 0, 0, 0);

    key(5'd1);
    key(5'd2);
    key(5'd3);
    key(5'd4);
    chk_entry("e1234", 2, 3, 4);
    key(5'h0A);
    chk_store("conf234", 255, 234, 0, 0);

    key(5'd5);
    chk_entry("dig5", 0, 0, 5);
    key(5'h0B);
    chk_entry("clr", 0, 0, 0);
    chk_store("clr", 255, 234, 0, 0);

    // Strobe held high for five cycles: one shift only.
    @(negedge clk);
    digito        = 5'd7;
    cambio_digito = 1'b1;
    repeat (5) @(negedge clk);
    chk_entry("hold7", 0, 0, 7);
    cambio_digito = 1'b0;
    @(negedge clk);

    key(5'h0D);
    chk_entry("ign0D", 0, 0, 7);
    key(5'h0A);
    chk_entry("conf7", 0, 0, 0);
    chk_store("conf7", 255, 234, 7, 1);

    key(5'd5);
    chk_entry("full_dig", 0, 0, 0);
    key(5'h0A);
    chk_store("full_conf", 255, 234, 7, 1);
    key(5'h0B);
    chk_store("full_clr", 255, 234, 7, 1);

    key(5'h0C);
    chk_entry("restart2", 0, 0, 0);
    chk_store("restart2", 0, 0, 0, 0);

    key(5'd4);
    key(5'd5);
    chk_entry("e45", 0, 4, 5);
    @(negedge clk);
    reset         = 1'b1;
    digito        = 5'h0A;
    cambio_digito = 1'b1;
    @(negedge clk);
    reset         = 1'b0;
    cambio_digito = 1'b0;
    chk_entry("rst_win", 0, 0, 0);
    chk_store("rst_win", 0, 0, 0, 0);
    @(negedge clk);

    key(5'd6);
    key(5'h0A);
    chk_store("ptr_r", 6, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
